// File: rtl/calc_scheduler.sv
// calc_scheduler: shares one combinational NB-bit calculator between two
// requesters with round-robin arbitration, a programmable settle window and
// trapping of divide-by-zero / illegal opcodes before they reach the datapath.
// Optional macro CALC_SCHED_STATS_EN adds saturating stat_ops / stat_errs.
module calc_scheduler #(
  parameter int NB     = 48,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [NB-1:0] req0_a,
  input  logic [NB-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [NB-1:0] req1_a,
  input  logic [NB-1:0] req1_b,
  input  logic [2:0]    req1_op,
  output logic [NB-1:0] calc_a,
  output logic [NB-1:0] calc_b,
  output logic [2:0]    calc_operand,
  input  logic [NB-1:0] calc_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [NB-1:0] rsp_result,
  output logic          rsp_err
`ifdef CALC_SCHED_STATS_EN
  ,
  output logic [15:0]   stat_ops,
  output logic [15:0]   stat_errs
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_reg, state_next;
  logic          ptr_reg;    // preferred port when both request
  logic [CW-1:0] cnt_reg;    // remaining settle cycles
  logic          trap_reg;   // accepted op is a trap: datapath untouched

  logic          gsel;
  logic          accept;
  logic [1:0]    valid_vec;
  logic [1:0]    ready_vec;
  logic [NB-1:0] sel_a, sel_b;
  logic [2:0]    sel_op;
  logic          sel_trap;

  assign valid_vec = {req1_valid, req0_valid};

  // Lone requester wins; on a tie the round-robin pointer decides.
  assign gsel   = (req0_valid && req1_valid) ? ptr_reg : req1_valid;
  assign accept = (state_reg == IDLE) && (req0_valid || req1_valid);

  // Ready is combinational from valid, only in IDLE, forced low during reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == IDLE) && !rst && valid_vec[gi]
                             && (gsel == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign sel_a    = gsel ? req1_a  : req0_a;
  assign sel_b    = gsel ? req1_b  : req0_b;
  assign sel_op   = gsel ? req1_op : req0_op;
  assign sel_trap = (sel_op > 3'd4) || ((sel_op == 3'd3) && (sel_b == '0));

  assign rsp_valid = (state_reg == RESP);

  // Next-state logic; trapped ops also pass through EXEC for one cycle so the
  // error response always appears one edge after acceptance.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = EXEC;
      EXEC: if (cnt_reg == '0) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, arbitration pointer, calculator drive and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 1'b0;
      cnt_reg      <= '0;
      trap_reg     <= 1'b0;
      calc_a       <= '0;
      calc_b       <= '0;
      calc_operand <= '0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rsp_id  <= gsel;
            ptr_reg <= ~gsel;
            if (sel_trap) begin
              trap_reg <= 1'b1;
              cnt_reg  <= '0;
            end else begin
              trap_reg     <= 1'b0;
              cnt_reg      <= CNT_LOAD;
              calc_a       <= sel_a;
              calc_b       <= sel_b;
              calc_operand <= sel_op;
            end
          end
        end
        EXEC: begin
          if (cnt_reg == '0) begin
            rsp_result <= trap_reg ? '0 : calc_result;
            rsp_err    <= trap_reg;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_SCHED_STATS_EN
  // Saturating counters of completed responses and of error responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if ((state_reg == RESP) && rsp_ready) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_err && (stat_errs != 16'hFFFF)) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_scheduler.sv
// tb_calc_scheduler: directed bench for calc_scheduler with a timestamp-based
// transaction model, a per-cycle compare process and literal spot checks.
module tb_calc_scheduler;
  localparam int NB     = 48;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [NB-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic [NB-1:0] calc_a, calc_b, calc_result, rsp_result;
  logic [2:0]    calc_operand;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
`ifdef CALC_SCHED_STATS_EN
  logic [15:0]   stat_ops, stat_errs;
`endif

  int checks = 0;
  int failures = 0;

  calc_scheduler #(.NB(NB), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .calc_a(calc_a), .calc_b(calc_b), .calc_operand(calc_operand),
    .calc_result(calc_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
`ifdef CALC_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  // Bench-side calculator: 0 add, 1 sub, 2 mul, 3 signed div, 4 and.
  function automatic logic [NB-1:0] calc_fn(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                            input logic [2:0] op);
    logic signed [NB-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return (b == '0) ? '0 : NB'(sa / sb);
      3'd4: return a & b;
      default: return '0;
    endcase
  endfunction

  assign calc_result = calc_fn(calc_a, calc_b, calc_operand);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
  endtask

  // ---------------- transaction model ----------------
  int            edge_cnt = 0;
  bit            m_busy, m_resp, m_ptr, m_id, m_trap, m_err;
  int            m_done_edge;
  logic [NB-1:0] m_a, m_b, m_res, m_ca, m_cb;
  logic [2:0]    m_op, m_cop;
  int            m_ops, m_errs;

  task automatic reset_model();
    m_busy = 0; m_resp = 0; m_ptr = 0; m_id = 0; m_trap = 0; m_err = 0;
    m_done_edge = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0;
    m_ca = '0; m_cb = '0; m_cop = '0; m_ops = 0; m_errs = 0;
  endtask

  task automatic step_model();
    int g;
    edge_cnt++;
    if (m_resp) begin
      if (rsp_ready) begin
        m_resp = 0;
        m_busy = 0;
        if (m_ops < 65535) m_ops++;
        if (m_err && m_errs < 65535) m_errs++;
      end
    end else if (m_busy) begin
      if (edge_cnt == m_done_edge) begin
        m_resp = 1;
        m_err  = m_trap;
        m_res  = m_trap ? '0 : calc_fn(m_a, m_b, m_op);
      end
    end else begin
      g = -1;
      if (req0_valid && req1_valid) g = m_ptr ? 1 : 0;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      if (g >= 0) begin
        m_id   = (g == 1);
        m_ptr  = (g == 0);
        m_a    = (g == 1) ? req1_a  : req0_a;
        m_b    = (g == 1) ? req1_b  : req0_b;
        m_op   = (g == 1) ? req1_op : req0_op;
        m_trap = (m_op > 3'd4) || (m_op == 3'd3 && m_b == '0);
        m_busy = 1;
        if (m_trap) m_done_edge = edge_cnt + 1;
        else begin
          m_done_edge = edge_cnt + SETTLE;
          m_ca = m_a; m_cb = m_b; m_cop = m_op;
        end
      end
    end
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) reset_model();
      else step_model();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_calc_a", calc_a, 0);
        chk("rst_calc_op", calc_operand, 0);
      end else begin
        chk("cmp_req0_ready", req0_ready,
            !m_busy && req0_valid && (!req1_valid || !m_ptr));
        chk("cmp_req1_ready", req1_ready,
            !m_busy && req1_valid && (!req0_valid || m_ptr));
        chk("cmp_rsp_valid", rsp_valid, m_resp);
        if (m_resp) begin
          chk("cmp_rsp_id", rsp_id, m_id);
          chk("cmp_rsp_result", rsp_result, m_res);
          chk("cmp_rsp_err", rsp_err, m_err);
        end
        chk("cmp_calc_a", calc_a, m_ca);
        chk("cmp_calc_b", calc_b, m_cb);
        chk("cmp_calc_op", calc_operand, m_cop);
      end
`ifdef CALC_SCHED_STATS_EN
      chk("cmp_stat_ops", stat_ops, rst ? 0 : m_ops);
      chk("cmp_stat_errs", stat_errs, rst ? 0 : m_errs);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  int            acc_edge, rsp_edge;
  logic          got_id, got_err;
  logic [NB-1:0] got_res;

  task automatic drive(input int p, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [2:0] op);
    @(posedge clk);
    #1;
    if (p == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  task automatic wait_accept(input int p);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        acc_edge = edge_cnt + 1;
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 0; else req1_valid = 0;
        return;
      end
    end
    note_fail("accept_timeout");
  endtask

  task automatic issue(input int p, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [2:0] op);
    drive(p, a, b, op);
    wait_accept(p);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_id = rsp_id; got_res = rsp_result; got_err = rsp_err;
        rsp_edge = edge_cnt;
        @(posedge clk);
        #1;
        return;
      end
    end
    note_fail("rsp_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // ---------------- directed sequence ----------------
  int   grants[$];
  int   n;
  bit   r0, r1;
  logic [NB-1:0] t_res;

  initial begin
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_rsp_valid", rsp_valid, 0);

    // 20 / 3 on port 0
    issue(0, 48'd20, 48'd3, 3'd3);
    wait_rsp();
    chk("t1_result", got_res, 6);
    chk("t1_err", got_err, 0);
    chk("t1_id", got_id, 0);
    chk("t1_latency", rsp_edge - acc_edge, 2);

    // divide by zero on port 1: datapath left alone
    issue(1, 48'd1, 48'd0, 3'd3);
    wait_rsp();
    chk("t2_err", got_err, 1);
    chk("t2_result", got_res, 0);
    chk("t2_id", got_id, 1);
    chk("t2_latency", rsp_edge - acc_edge, 1);
    chk("t2_calc_a", calc_a, 20);
    chk("t2_calc_b", calc_b, 3);
    chk("t2_calc_op", calc_operand, 3);

    // both ports valid from reset: strict alternation
    @(posedge clk);
    #1 rst = 1;
    req0_valid = 1; req0_a = 48'd100; req0_b = 48'd1; req0_op = 3'd0;
    req1_valid = 1; req1_a = 48'd200; req1_b = 48'd2; req1_op = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < 8; cyc++) begin
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready;
      if (r0 || r1) begin
        chk("rr_onehot", {r0, r1}, r0 ? 2'b10 : 2'b01);
        grants.push_back(r0 ? 0 : 1);
        @(posedge clk);
        #1;
        if (r0) begin req0_a = 48'd300 + 48'(n); req0_b = 48'(n); end
        else    begin req1_a = 48'd400 + 48'(n); req1_b = 48'(n); end
        n++;
        if (n == 8) begin req0_valid = 0; req1_valid = 0; end
      end
    end
    if (n < 8) note_fail("rr_timeout");
    for (int i = 0; i < grants.size(); i++) chk("rr_order", grants[i], i % 2);
    wait_rsp();

    // response stall: hold rsp_ready low with port 1 waiting
    rsp_ready = 0;
    issue(0, 48'd7, 48'd6, 3'd2);
    drive(1, 48'd9, 48'd4, 3'd1);
    begin : stall_blk
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      if (!seen) note_fail("stall_rsp_timeout");
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_result", rsp_result, 42);
      chk("stall_id", rsp_id, 0);
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1;
    @(negedge clk);
    chk("stall_hold_before_hs", rsp_valid, 1);
    @(negedge clk);
    chk("stall_released", rsp_valid, 0);
    chk("stall_next_ready1", req1_ready, 1);
    wait_accept(1);
    wait_rsp();
    chk("stall_p1_result", got_res, 5);
    chk("stall_p1_id", got_id, 1);

    // illegal opcode then zero dividend
    issue(0, 48'd5, 48'd5, 3'd7);
    wait_rsp();
    chk("t5_err", got_err, 1);
    chk("t5_result", got_res, 0);
    issue(0, 48'd0, 48'd3, 3'd3);
    wait_rsp();
    chk("t5b_err", got_err, 0);
    chk("t5b_result", got_res, 0);

    // negative operand passes through untouched: -21 / 4 = -5
    t_res = -48'sd21;
    issue(1, t_res, 48'd4, 3'd3);
    wait_rsp();
    t_res = -48'sd5;
    chk("neg_div_result", got_res, t_res);

    // reset while an op is in EXEC
    issue(0, 48'd100, 48'd7, 3'd3);
    req0_valid = 1; req0_a = 48'd11; req0_b = 48'd2; req0_op = 3'd2;
    req1_valid = 1; req1_a = 48'd8;  req1_b = 48'd8; req1_op = 3'd0;
    #1 rst = 1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_calc_a", calc_a, 0);
    chk("midrst_ready0", req0_ready, 0);
    chk("midrst_ready1", req1_ready, 0);
`ifdef CALC_SCHED_STATS_EN
    chk("midrst_stat_ops", stat_ops, 0);
    chk("midrst_stat_errs", stat_errs, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("postrst_ready0", req0_ready, 1);
    chk("postrst_ready1", req1_ready, 0);
    @(posedge clk);
    #1 req0_valid = 0;
    req1_valid = 0;
    wait_rsp();
    chk("postrst_result", got_res, 22);
    chk("postrst_id", got_id, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    note_fail("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end
endmodule
